banked_lcdram: RTL and testbench

BANKED_LCDRAM -- requirements
Module: banked_lcdram

---
 rtl/banked_lcdram.sv | 238 +++++++++++++++++++++++
 tb/tb_banked_lcdram.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_lcdram.sv
// banked_lcdram: banked video RAM shared by a CPU bus and a PPU port.
// The PPU always owns the single-port array; CPU accesses wait in PEND.
module banked_lcdram #(
   parameter logic [15:0] BASE_ADDR     = 16'h8000,
   parameter int unsigned WINDOW_SIZE   = 'h2000,
   parameter int unsigned NUM_BANKS     = 2,
   parameter logic [15:0] BANK_REG_ADDR = 16'hFF4F,
   localparam int BANK_W = $clog2(NUM_BANKS),
   localparam int OFF_W  = $clog2(WINDOW_SIZE)
) (
   input  logic              I_MEM_CLK,
   input  logic              I_RESET,
   input  logic [15:0]       I_LCDRAM_ADDR,
   inout  wire  [7:0]        IO_LCDRAM_DATA,
   input  logic              I_LCDRAM_WE_L,
   input  logic              I_LCDRAM_RE_L,
   input  logic              I_PPU_REQ,
   input  logic [BANK_W-1:0] I_PPU_BANK,
   input  logic [OFF_W-1:0]  I_PPU_ADDR,
   input  logic              I_PPU_LOCK,
   output logic [7:0]        O_PPU_DATA,
   output logic              O_PPU_VALID,
   output logic [BANK_W-1:0] O_BANK,
   output logic              O_CPU_BLOCKED
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_RDONE} state_t;

   localparam int AW    = BANK_W + OFF_W;
   localparam int DEPTH = int'(NUM_BANKS * WINDOW_SIZE);

   logic [7:0]        mem [DEPTH];

   logic              we_q, re_q;
   logic              we_edge, re_edge, cpu_edge, cpu_wr;
   logic [15:0]       off_full;
   logic              win_hit, reg_hit, win_edge;
   state_t            state, state_nxt;
   logic [BANK_W-1:0] bank_q;
   logic              breg_rd;

   logic              h_wr;
   logic [BANK_W-1:0] h_bank;
   logic [OFF_W-1:0]  h_off;
   logic [7:0]        h_data;

   logic              mem_en, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [7:0]        mem_wd, mem_q;
   logic              cpu_rd_go, lock_rd, hold_ld, blocked;

   logic              rd_cap_q, lock_q, rd_vld, blocked_q;
   logic [7:0]        rd_q;
   logic              ppu_vld;
   logic [7:0]        ppu_last;
   logic              drv_win, drv_reg;
   logic [7:0]        drv_val;

   assign cpu_wr   = ~I_LCDRAM_WE_L;
   assign we_edge  = ~I_LCDRAM_WE_L & we_q;
   assign re_edge  = ~I_LCDRAM_RE_L & re_q;
   assign cpu_edge = we_edge | re_edge;
   assign off_full = I_LCDRAM_ADDR - BASE_ADDR;
   assign reg_hit  = (I_LCDRAM_ADDR == BANK_REG_ADDR);
   assign win_hit  = ~reg_hit && (I_LCDRAM_ADDR >= BASE_ADDR)
                     && (32'(off_full) < WINDOW_SIZE);
   assign win_edge = cpu_edge & win_hit;

   // strobe history for falling-edge detection
   always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         we_q <= 1'b1;
         re_q <= 1'b1;
      end else begin
         we_q <= I_LCDRAM_WE_L;
         re_q <= I_LCDRAM_RE_L;
      end
   end

   // bank-select register, bypasses arbitration entirely
   always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         bank_q  <= '0;
         breg_rd <= 1'b0;
      end else begin
         if (cpu_edge && reg_hit && cpu_wr)
            bank_q <= IO_LCDRAM_DATA[BANK_W-1:0];
         if (I_LCDRAM_RE_L)
            breg_rd <= 1'b0;
         else if (re_edge && reg_hit && !cpu_wr)
            breg_rd <= 1'b1;
      end
   end

   // arbiter state register
   always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
      if (I_RESET) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // arbiter next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (win_edge && !I_PPU_LOCK && I_PPU_REQ)
               state_nxt = S_PEND;
            else if (win_edge && !cpu_wr)
               state_nxt = S_RDONE;
         end
         S_PEND: begin
            if (!I_PPU_REQ)
               state_nxt = h_wr ? S_IDLE : S_RDONE;
         end
         S_RDONE: begin
            if (I_LCDRAM_RE_L)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // arbiter outputs: array port steering, hold load, drop pulses
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wd    = '0;
      cpu_rd_go = 1'b0;
      lock_rd   = 1'b0;
      hold_ld   = 1'b0;
      blocked   = 1'b0;
      if (I_PPU_REQ) begin
         mem_en   = 1'b1;
         mem_addr = {I_PPU_BANK, I_PPU_ADDR};
      end
      unique case (state)
         S_IDLE: begin
            if (win_edge) begin
               if (I_PPU_LOCK) begin
                  blocked = 1'b1;
                  lock_rd = ~cpu_wr;
               end else if (I_PPU_REQ) begin
                  hold_ld = 1'b1;
               end else begin
                  mem_en    = 1'b1;
                  mem_we    = cpu_wr;
                  mem_addr  = {bank_q, off_full[OFF_W-1:0]};
                  mem_wd    = IO_LCDRAM_DATA;
                  cpu_rd_go = ~cpu_wr;
               end
            end
         end
         S_PEND: begin
            if (win_edge)
               blocked = 1'b1;
            if (!I_PPU_REQ) begin
               mem_en    = 1'b1;
               mem_we    = h_wr;
               mem_addr  = {h_bank, h_off};
               mem_wd    = h_data;
               cpu_rd_go = ~h_wr;
            end
         end
         default: ;
      endcase
   end

   // hold register for a CPU access displaced by the PPU
   always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         h_wr   <= 1'b0;
         h_bank <= '0;
         h_off  <= '0;
         h_data <= '0;
      end else if (hold_ld) begin
         h_wr   <= cpu_wr;
         h_bank <= bank_q;
         h_off  <= off_full[OFF_W-1:0];
         h_data <= IO_LCDRAM_DATA;
      end
   end

   // single-port synchronous array, contents survive reset
   always_ff @(posedge I_MEM_CLK) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wd;
         else        mem_q <= mem[mem_addr];
      end
   end

   // CPU read data register and drop pulse
   always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         rd_cap_q  <= 1'b0;
         lock_q    <= 1'b0;
         rd_vld    <= 1'b0;
         rd_q      <= '0;
         blocked_q <= 1'b0;
      end else begin
         rd_cap_q  <= cpu_rd_go | lock_rd;
         lock_q    <= lock_rd;
         blocked_q <= blocked;
         if (rd_cap_q)
            rd_q <= lock_q ? 8'hFF : mem_q;
         if (state == S_RDONE && I_LCDRAM_RE_L)
            rd_vld <= 1'b0;
         else if (rd_cap_q)
            rd_vld <= 1'b1;
      end
   end

   // PPU valid pulse and last-value hold
   always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         ppu_vld  <= 1'b0;
         ppu_last <= '0;
      end else begin
         ppu_vld <= I_PPU_REQ;
         if (ppu_vld)
            ppu_last <= mem_q;
      end
   end

   assign O_PPU_DATA    = ppu_vld ? mem_q : ppu_last;
   assign O_PPU_VALID   = ppu_vld;
   assign O_BANK        = bank_q;
   assign O_CPU_BLOCKED = blocked_q;

   assign drv_win = (state == S_RDONE) && rd_vld && win_hit
                    && !I_LCDRAM_RE_L && I_LCDRAM_WE_L;
   assign drv_reg = breg_rd && reg_hit
                    && !I_LCDRAM_RE_L && I_LCDRAM_WE_L;
   assign drv_val = drv_reg ? {{(8-BANK_W){1'b1}}, bank_q} : rd_q;

   assign IO_LCDRAM_DATA = (drv_win || drv_reg) ? drv_val : 8'bz;

endmodule

// File: tb/tb_banked_lcdram.sv
// tb_banked_lcdram: directed vectors for banked_lcdram.
// The data bus is pulled up, so an undriven bus reads 8'hFF.
module tb_banked_lcdram;

   typedef struct {
      logic        wr;
      logic        lk;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp1;
      logic [7:0]  exp2;
      logic        blk;
      logic [0:0]  bank;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic        we_l = 1'b1;
   logic        re_l = 1'b1;
   logic        ppu_req = 1'b0;
   logic [0:0]  ppu_bank = 1'b0;
   logic [12:0] ppu_addr = 13'h0;
   logic        lock = 1'b0;
   logic [7:0]  ppu_data;
   logic        ppu_valid;
   logic [0:0]  o_bank;
   logic        blocked;
   logic [7:0]  drv = 8'h00;
   logic        drv_en = 1'b0;
   wire  [7:0]  bus;

   int n_run  = 0;
   int n_fail = 0;
   int n_vld  = 0;

   vec_t tbl [21];

   assign bus = drv_en ? drv : 8'bz;

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (bus[g]);
   end

   always #5 clk = ~clk;

   banked_lcdram dut (
      .I_MEM_CLK      (clk),
      .I_RESET        (rst),
      .I_LCDRAM_ADDR  (addr),
      .IO_LCDRAM_DATA (bus),
      .I_LCDRAM_WE_L  (we_l),
      .I_LCDRAM_RE_L  (re_l),
      .I_PPU_REQ      (ppu_req),
      .I_PPU_BANK     (ppu_bank),
      .I_PPU_ADDR     (ppu_addr),
      .I_PPU_LOCK     (lock),
      .O_PPU_DATA     (ppu_data),
      .O_PPU_VALID    (ppu_valid),
      .O_BANK         (o_bank),
      .O_CPU_BLOCKED  (blocked)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      lock = v.lk;
      addr = v.addr;
      if (v.wr) begin
         drv    = v.data;
         drv_en = 1'b1;
         we_l   = 1'b0;
      end else begin
         re_l = 1'b0;
      end
      tick();
      chk({nm, ".blk"}, 16'(blocked), 16'(v.blk));
      if (!v.wr)
         chk({nm, ".rd1"}, 16'(bus), 16'(v.exp1));
      we_l   = 1'b1;
      drv_en = 1'b0;
      if (!v.wr) begin
         tick();
         chk({nm, ".rd2"}, 16'(bus), 16'(v.exp2));
         re_l = 1'b1;
      end
      tick();
      chk({nm, ".bank"}, 16'(o_bank), 16'(v.bank));
      lock = 1'b0;
   endtask

   initial begin
      //         wr    lk    addr      data   exp1   exp2   blk   bank
      tbl[0]  = '{1'b1, 1'b0, 16'h8010, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 16'hFF4F, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 16'h8010, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 16'h8010, 8'h00, 8'hFF, 8'h5A, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 16'hFF4F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 16'h8010, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 16'hFF4F, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 16'h8000, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 16'hA000, 8'h77, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 16'h8000, 8'h00, 8'hFF, 8'h3C, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 16'h9FFF, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 16'h7FFF, 8'h66, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 16'h9FFF, 8'h00, 8'hFF, 8'hC3, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 16'hA000, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 16'h7FFF, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 16'h8000, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 16'h8000, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
      tbl[17] = '{1'b1, 1'b1, 16'hFF4F, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 16'hFF4F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 16'h8000, 8'h00, 8'hFF, 8'h3C, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 1'b0, 16'hFF4F, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b0};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst.bank", 16'(o_bank), 16'h0);
      chk("rst.pvld", 16'(ppu_valid), 16'h0);
      chk("rst.pdat", 16'(ppu_data), 16'h00);
      chk("rst.blk", 16'(blocked), 16'h0);
      chk("rst.bus", 16'(bus), 16'hFF);

      for (int i = 0; i < 21; i++)
         run_vec(tbl[i], $sformatf("v%0d", i));

      // PPU single read: valid exactly one cycle after the request
      ppu_req  = 1'b1;
      ppu_bank = 1'b1;
      ppu_addr = 13'h0010;
      chk("ppu.pre", 16'(ppu_valid), 16'h0);
      tick();
      chk("ppu.vld", 16'(ppu_valid), 16'h1);
      chk("ppu.dat", 16'(ppu_data), 16'h5A);
      ppu_req = 1'b0;
      tick();
      chk("ppu.end", 16'(ppu_valid), 16'h0);
      chk("ppu.hold", 16'(ppu_data), 16'h5A);

      // PPU back-to-back: 8 requests, 8 consecutive valid pulses
      for (int i = 0; i < 8; i++)
         run_vec('{1'b1, 1'b0, 16'h8020 + 16'(i), 8'h40 + 8'(i),
                   8'h00, 8'h00, 1'b0, 1'b0}, $sformatf("pre%0d", i));
      ppu_bank = 1'b0;
      ppu_req  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ppu_addr = 13'h020 + 13'(i);
         tick();
         if (ppu_valid) n_vld++;
         chk($sformatf("b2b%0d", i), 16'(ppu_data), 16'(8'h40 + 8'(i)));
      end
      ppu_req = 1'b0;
      tick();
      chk("b2b.cnt", 16'(n_vld), 16'd8);
      chk("b2b.end", 16'(ppu_valid), 16'h0);

      // CPU read held in PEND across 3 PPU cycles; second edge dropped
      addr     = 16'h8010;
      re_l     = 1'b0;
      ppu_req  = 1'b1;
      ppu_bank = 1'b1;
      ppu_addr = 13'h0010;
      tick();
      chk("pend.z1", 16'(bus), 16'hFF);
      drv    = 8'h99;
      drv_en = 1'b1;
      we_l   = 1'b0;
      tick();
      chk("pend.blk", 16'(blocked), 16'h1);
      we_l   = 1'b1;
      drv_en = 1'b0;
      tick();
      chk("pend.blk0", 16'(blocked), 16'h0);
      ppu_req = 1'b0;
      tick();
      chk("pend.z4", 16'(bus), 16'hFF);
      tick();
      chk("pend.d5", 16'(bus), 16'hA5);
      re_l = 1'b1;
      tick();
      run_vec('{1'b0, 1'b0, 16'h8010, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0},
              "pend.nowr");

      // reset while a write is held in PEND
      run_vec('{1'b1, 1'b0, 16'hFF4F, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1},
              "rp.bank");
      addr     = 16'h8010;
      drv      = 8'hEE;
      drv_en   = 1'b1;
      we_l     = 1'b0;
      ppu_req  = 1'b1;
      ppu_bank = 1'b0;
      ppu_addr = 13'h0030;
      tick();
      rst     = 1'b1;
      we_l    = 1'b1;
      drv_en  = 1'b0;
      ppu_req = 1'b0;
      #1;
      chk("rp.obank", 16'(o_bank), 16'h0);
      chk("rp.pvld", 16'(ppu_valid), 16'h0);
      chk("rp.pdat", 16'(ppu_data), 16'h00);
      chk("rp.blk", 16'(blocked), 16'h0);
      chk("rp.bus", 16'(bus), 16'hFF);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("rp.blk2", 16'(blocked), 16'h0);
      ppu_req  = 1'b1;
      ppu_bank = 1'b1;
      ppu_addr = 13'h0010;
      tick();
      ppu_req = 1'b0;
      chk("rp.keep", 16'(ppu_data), 16'h5A);
      run_vec('{1'b0, 1'b0, 16'h8010, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0},
              "rp.fresh");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
